// File: rtl/capture_playback_pkg.sv
// Shared types and default timing constants for the capture/playback buffer.
package capture_playback_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_e;

   localparam int unsigned TICK_DIV_DEF   = 100_000_000;  // 1 s at 100 MHz
   localparam int unsigned DEB_CYCLES_DEF = 1_000_000;    // 10 ms at 100 MHz

endpackage

// File: rtl/capture_playback_btn_debounce.sv
// Raw button -> 2-flop synchronizer -> stability debouncer -> one-cycle rising-edge pulse.
module btn_debounce
   import capture_playback_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic            r_sync1;
   logic            r_sync2;
   logic            r_state;
   logic [CntW-1:0] r_cnt;
   logic            r_pulse;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= 1'b0;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_pulse <= 1'b0;
         if (r_sync2 == r_state) begin
            r_cnt <= '0;
         end else if (r_cnt == CntW'(DEB_CYCLES - 1)) begin
            // New level held for DEB_CYCLES consecutive cycles: accept it
            r_state <= r_sync2;
            r_cnt   <= '0;
            r_pulse <= r_sync2;
         end else begin
            r_cnt <= r_cnt + CntW'(1);
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/capture_playback.sv
// Byte capture buffer: record switch values on button presses, then replay them on the LEDs.
module capture_playback
   import capture_playback_pkg::*;
#(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_btn_cap,
   input  logic                     i_btn_play,
   input  logic                     i_btn_clr,
   input  logic [7:0]               i_data,
   output logic [7:0]               o_led,
   output logic                     o_playing,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic w_cap_p, w_play_p, w_clr_p;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cap (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_btn_cap),
      .o_pulse (w_cap_p)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_play (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_btn_play),
      .o_pulse (w_play_p)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_btn_clr),
      .o_pulse (w_clr_p)
   );

   state_e          r_state, w_state_nxt;
   logic [CW-1:0]   r_count, w_count_nxt;
   logic [AW-1:0]   r_rd_idx, w_idx_nxt;
   logic [TW-1:0]   r_timer, w_timer_nxt;
   logic [7:0]      r_led, w_led_nxt;
   logic [7:0]      r_mem [DEPTH];
   logic            w_wr_en;
   logic            w_full;

   assign w_full = (r_count == CW'(DEPTH));

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_idx_nxt   = r_rd_idx;
      w_timer_nxt = r_timer;
      w_wr_en     = 1'b0;
      w_led_nxt   = i_data;

      if (w_clr_p) begin
         w_count_nxt = '0;
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_cap_p && !w_full) begin
                  w_wr_en     = 1'b1;
                  w_count_nxt = r_count + CW'(1);
               end
               // Uses the post-write count so capture+play together replays the new byte
               if (w_play_p && (w_count_nxt != '0)) begin
                  w_state_nxt = PLAY;
                  w_idx_nxt   = '0;
                  w_timer_nxt = '0;
               end
            end
            PLAY: begin
               if (w_play_p) begin
                  w_state_nxt = IDLE;
               end else if (r_timer == TW'(TICK_DIV - 1)) begin
                  w_timer_nxt = '0;
                  if ({1'b0, r_rd_idx} == (r_count - CW'(1))) begin
                     w_state_nxt = IDLE;
                  end else begin
                     w_idx_nxt = r_rd_idx + AW'(1);
                  end
               end else begin
                  w_timer_nxt = r_timer + TW'(1);
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end

      if (w_state_nxt == PLAY) begin
         // Bypass the entry being written on this same edge
         if (w_wr_en && (w_idx_nxt == r_count[AW-1:0])) begin
            w_led_nxt = i_data;
         end else begin
            w_led_nxt = r_mem[w_idx_nxt];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_rd_idx <= '0;
         r_timer  <= '0;
         r_led    <= 8'h00;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_rd_idx <= w_idx_nxt;
         r_timer  <= w_timer_nxt;
         r_led    <= w_led_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[r_count[AW-1:0]] <= i_data;
      end
   end

   assign o_led     = r_led;
   assign o_playing = (r_state == PLAY);
   assign o_full    = w_full;
   assign o_count   = r_count;

endmodule

// File: tb/tb_capture_playback.sv
// Scoreboard bench for capture_playback with a behavioural model of presses and playback.
module tb_capture_playback;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TICK  = 4;
   localparam int unsigned DEB   = 2;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       btn_cap  = 1'b0;
   logic       btn_play = 1'b0;
   logic       btn_clr  = 1'b0;
   logic [7:0] data     = 8'h00;
   logic [7:0] led;
   logic       playing;
   logic       full;
   logic [2:0] count;

   always #5 clk = ~clk;

   capture_playback #(
      .DEPTH      (DEPTH),
      .TICK_DIV   (TICK),
      .DEB_CYCLES (DEB)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_btn_cap  (btn_cap),
      .i_btn_play (btn_play),
      .i_btn_clr  (btn_clr),
      .i_data     (data),
      .o_led      (led),
      .o_playing  (playing),
      .o_full     (full),
      .o_count    (count)
   );

   typedef struct packed {
      logic [7:0] led;
      logic       playing;
      logic       full;
      logic [2:0] count;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
      end
   endtask

   // Reference model: a press is accepted once the raw level has held for DEB
   // samples; it then acts on the buffer three edges later (sync + pulse register).
   logic [7:0] m_mem [DEPTH];
   int         m_cnt, m_idx, m_shown, cyc;
   bit         m_play;
   bit         m_acc  [3];
   int         m_run  [3];
   int         m_fire [3];

   initial begin : model
      logic [2:0] raw;
      bit         p [3];
      exp_t       e;
      cyc = 0;
      forever begin
         @(posedge clk);
         raw = {btn_clr, btn_play, btn_cap};
         if (!rst_n) begin
            m_cnt  = 0;
            m_play = 0;
            m_idx  = 0;
            for (int b = 0; b < 3; b++) begin
               m_acc[b]  = 0;
               m_run[b]  = 0;
               m_fire[b] = -1;
            end
            e = '0;
         end else begin
            for (int b = 0; b < 3; b++) begin
               p[b] = (m_fire[b] == cyc);
               if (p[b]) m_fire[b] = -1;
               if (raw[b] != m_acc[b]) m_run[b]++;
               else m_run[b] = 0;
               if (m_run[b] == DEB) begin
                  m_acc[b] = raw[b];
                  m_run[b] = 0;
                  if (m_acc[b]) m_fire[b] = cyc + 3;
               end
            end
            if (p[2]) begin
               m_cnt  = 0;
               m_play = 0;
            end else if (!m_play) begin
               if (p[0] && m_cnt < DEPTH) begin
                  m_mem[m_cnt] = data;
                  m_cnt++;
               end
               if (p[1] && m_cnt > 0) begin
                  m_play  = 1;
                  m_idx   = 0;
                  m_shown = 1;
               end
            end else if (p[1]) begin
               m_play = 0;
            end else if (m_shown == TICK) begin
               m_shown = 1;
               if (m_idx == m_cnt - 1) m_play = 0;
               else m_idx++;
            end else begin
               m_shown++;
            end
            e.led     = m_play ? m_mem[m_idx] : data;
            e.playing = m_play;
            e.full    = (m_cnt == DEPTH);
            e.count   = 3'(m_cnt);
         end
         exp_q.push_back(e);
         cyc++;
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("led",     int'(led),     int'(e.led));
            chk("playing", int'(playing), int'(e.playing));
            chk("full",    int'(full),    int'(e.full));
            chk("count",   int'(count),   int'(e.count));
         end
      end
   end

   // d < 0 selects a fresh random data byte every cycle
   task automatic drv(input bit c, input bit p, input bit k, input int n, input int d);
      repeat (n) begin
         @(negedge clk);
         btn_cap  = c;
         btn_play = p;
         btn_clr  = k;
         data     = (d < 0) ? 8'($urandom) : 8'(d);
      end
   endtask

   task automatic rst(input int n);
      repeat (n) begin
         @(negedge clk);
         rst_n    = 1'b0;
         btn_cap  = 1'b0;
         btn_play = 1'b0;
         btn_clr  = 1'b0;
         data     = 8'($urandom);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : stim
      int sel, hold, gap;
      rst(3);

      // Two captures then full playback, led returns to tracking data
      drv(1, 0, 0, 3, 'hA5); drv(0, 0, 0, 5, 'hA5);
      drv(1, 0, 0, 3, 'h3C); drv(0, 0, 0, 5, 'h3C);
      drv(0, 1, 0, 3, 'h77); drv(0, 0, 0, 16, -1);

      // Overfill: fifth capture dropped
      drv(0, 0, 1, 3, -1); drv(0, 0, 0, 5, -1);
      for (int v = 1; v <= 5; v++) begin
         drv(1, 0, 0, 3, v * 'h11); drv(0, 0, 0, 4, v * 'h11);
      end

      // Abort during the second entry, then replay from the start
      drv(0, 1, 0, 3, -1); drv(0, 0, 0, 2, -1);
      drv(0, 1, 0, 3, -1); drv(0, 0, 0, 6, -1);
      drv(0, 1, 0, 3, -1); drv(0, 0, 0, 22, -1);

      // Play on an empty buffer is ignored
      drv(0, 0, 1, 3, -1); drv(0, 0, 0, 5, -1);
      drv(0, 1, 0, 3, -1); drv(0, 0, 0, 8, -1);

      // Clear beats simultaneous capture; single-cycle glitch is filtered
      drv(1, 0, 0, 3, 'h5A); drv(0, 0, 0, 5, -1);
      drv(1, 0, 1, 3, 'hEE); drv(0, 0, 0, 6, -1);
      drv(1, 0, 0, 1, 'hEE); drv(0, 0, 0, 6, -1);

      // Simultaneous capture+play from empty replays the new byte
      drv(1, 1, 0, 3, 'hC3); drv(0, 0, 0, 8, -1);

      // Reset in the middle of playback
      drv(1, 0, 0, 3, 'h12); drv(0, 0, 0, 5, -1);
      drv(0, 1, 0, 3, -1);   drv(0, 0, 0, 6, -1);
      rst(1);                drv(0, 0, 0, 6, -1);

      for (int i = 0; i < 400; i++) begin
         sel  = $urandom_range(0, 19);
         hold = $urandom_range(1, 4);
         gap  = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 12);
         if (sel == 19) begin
            rst($urandom_range(1, 2));
         end else if (sel <= 7) begin
            drv(1, 0, 0, hold, -1);
         end else if (sel <= 12) begin
            drv(0, 1, 0, hold, -1);
         end else if (sel == 13) begin
            drv(0, 0, 1, hold, -1);
         end else if (sel == 14) begin
            drv(1, 1, 0, hold, -1);
         end else if (sel == 15) begin
            drv(1, 0, 1, hold, -1);
         end else if (sel == 16) begin
            drv(0, 1, 1, hold, -1);
         end
         drv(0, 0, 0, gap, -1);
      end

      drv(0, 0, 0, 10, -1);
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/capture_playback.md
CAPTURE_PLAYBACK -- requirements
Module: capture_playback

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of byte entries held in the buffer (power of two, 2..16).
REQ-002 Parameter TICK_DIV, default 100_000_000, SHALL set the clk cycles each entry is shown during playback (1 s at 100 MHz).
REQ-003 Parameter DEB_CYCLES, default 1_000_000, SHALL set the clk cycles a button must stay stable before it is accepted (10 ms).
REQ-004 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-006 btn_cap  input  1  SHALL be the raw capture button, asynchronous to clk.
REQ-007 btn_play  input  1  SHALL be the raw play/abort button, asynchronous to clk.
REQ-008 btn_clr  input  1  SHALL be the raw clear button, asynchronous to clk.
REQ-009 data  input  8  SHALL be the slide-switch byte to capture.
REQ-010 led  output  8  SHALL be the registered display byte.
REQ-011 playing  output  1  SHALL be high exactly while the FSM is in PLAY.
REQ-012 full  output  1  SHALL be high when count equals DEPTH.
REQ-013 count  output  $clog2(DEPTH)+1  SHALL give the number of valid entries.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer, then rising-edge detection, giving a one-cycle pulse (cap_p, play_p, clr_p) per accepted press.
REQ-015 Pulse latency SHALL be 2 sync cycles + DEB_CYCLES + 1 cycle after the raw level settles; glitches shorter than DEB_CYCLES SHALL produce no pulse.
REQ-016 The FSM SHALL have two states: IDLE and PLAY.
REQ-017 In IDLE, led SHALL load data every cycle (one-cycle latency from data to led).
REQ-018 In IDLE, cap_p with count<DEPTH SHALL write data into entry[count] and increment count in the same cycle.
REQ-019 In IDLE, cap_p with count==DEPTH SHALL be ignored; entries and count unchanged.
REQ-020 In IDLE, play_p with count>0 SHALL enter PLAY, set rd_idx=0, clear the tick timer and load led=entry[0] on that edge.
REQ-021 In IDLE, play_p with count==0 SHALL be ignored.
REQ-022 In PLAY, led SHALL hold entry[rd_idx]; the tick timer SHALL count 0..TICK_DIV-1 and on reaching TICK_DIV-1 SHALL wrap to 0 and advance.
REQ-023 Advance with rd_idx<count-1 SHALL increment rd_idx and load led=entry[rd_idx+1].
REQ-024 Advance with rd_idx==count-1 SHALL return to IDLE; every entry is thus shown for exactly TICK_DIV cycles.
REQ-025 In PLAY, play_p SHALL abort to IDLE on the next edge.
REQ-026 In PLAY, cap_p SHALL be ignored.
REQ-027 Playback SHALL be non-destructive: entries and count survive PLAY and can be replayed.
REQ-028 clr_p in either state SHALL set count=0 and force IDLE; clr_p SHALL take priority over simultaneous cap_p or play_p.
REQ-029 Simultaneous cap_p and play_p in IDLE SHALL write first, then enter PLAY with the new count.

Reset
REQ-030 With rst_n low at a clk edge: state=IDLE, count=0, rd_idx=0, timer=0, led=8'h00, playing=0, full=0, synchronizer/debouncer state=released.
REQ-031 Entry storage SHALL NOT require reset; contents beyond count are don't-care.
REQ-032 Reset asserted mid-PLAY SHALL abort playback and discard all entries.

Structure
REQ-033 A shared package SHALL hold the state enumeration (IDLE, PLAY) and the default TICK_DIV and DEB_CYCLES constants.
REQ-034 One sub-module, btn_debounce (synchronizer + stability counter + edge pulse), SHALL be instantiated three times.

Verification (DEPTH=4, TICK_DIV=4, DEB_CYCLES=2)
REQ-035 Capture 8'hA5, 8'h3C; press play -> led=A5 for 4 cycles, 3C for 4 cycles, then follows data; playing high for exactly 8 cycles.
REQ-036 Five captures 11,22,33,44,55 -> count=4, full=1, entry[3]=44, 55 discarded.
REQ-037 Play with count=0 -> playing stays 0, led keeps tracking data.
REQ-038 Press play during second entry -> IDLE next cycle; replay restarts at entry[0].
REQ-039 Clear and capture pulses in same cycle -> count=0, nothing written; 1-cycle button glitch -> no pulse.
REQ-040 rst_n low mid-PLAY -> next edge led=00, playing=0, count=0.
